// File: rtl/cal_pkg.sv
// Shared calendar constants, bus-select codes and the BCD display helper.
// Used by the month/year stage and by any downstream display logic.
package cal_pkg;

  localparam int MONTH_MAX = 11;
  localparam int YEAR_MAX  = 99;
  localparam int YEAR_W    = 7;
  localparam int DATE_MAX  = 30;
  localparam int MONTH_W   = 4;

  localparam logic SEL_MONTH = 1'b0;
  localparam logic SEL_YEAR  = 1'b1;

  // Two-digit packed BCD (tens:ones); callers keep the input within 0..99.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    int tens;
    int ones;
    tens = int'(v) / 10;
    ones = int'(v) % 10;
    return {4'(tens), 4'(ones)};
  endfunction

endpackage

// File: rtl/month_year_mod_counter.sv
// Modulo-(MAX+1) counter with clamping load; clear > load > inc, state changes on the edge.
// wrap is combinational (inc at MAX) so a chained counter advances on the same edge.
module mod_counter
  import cal_pkg::*;
#(
  parameter int MAX = 11,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] load_clamped;

  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  assign wrap         = inc && (count == MAX_V);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_clamped;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/month_year.sv
// Month/year calendar stage fed by the date counter's rollover pulse; drives an enable-gated databus.
// Optional BCD display outputs under MONTH_YEAR_BCD_OUT_EN (registered, one cycle behind month/year).
module month_year #(
  parameter int MONTH_MAX = cal_pkg::MONTH_MAX,
  parameter int YEAR_MAX  = cal_pkg::YEAR_MAX,
  parameter int YEAR_W    = cal_pkg::YEAR_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              load_sel,
  input  logic [YEAR_W-1:0] data,
  input  logic              day_wrap,
  input  logic              enable,
  input  logic              bus_sel,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              year_wrap,
  output logic [YEAR_W-1:0] databus
`ifdef MONTH_YEAR_BCD_OUT_EN
  ,
  output logic [7:0]        month_bcd,
  output logic [7:0]        year_bcd
`endif
);

  import cal_pkg::*;

  logic month_load;
  logic year_load;
  logic month_inc;
  logic month_wrap;
  logic year_wrap_next;

  assign month_load = load && (load_sel == SEL_MONTH);
  assign year_load  = load && (load_sel == SEL_YEAR);
  // A load cycle swallows day_wrap completely, including any carry into the year.
  assign month_inc  = day_wrap && !load;

  mod_counter #(
    .MAX (MONTH_MAX),
    .W   (4)
  ) u_month (
    .clk      (clk),
    .clear    (clear),
    .load     (month_load),
    .load_val (data[3:0]),
    .inc      (month_inc),
    .count    (month),
    .wrap     (month_wrap)
  );

  mod_counter #(
    .MAX (YEAR_MAX),
    .W   (YEAR_W)
  ) u_year (
    .clk      (clk),
    .clear    (clear),
    .load     (year_load),
    .load_val (data),
    .inc      (month_wrap),
    .count    (year),
    .wrap     (year_wrap_next)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      year_wrap <= 1'b0;
    end else begin
      year_wrap <= year_wrap_next;
    end
  end

  always_comb begin
    databus = '0;
    if (enable) begin
      if (bus_sel == SEL_YEAR) begin
        databus = year;
      end else begin
        databus = YEAR_W'(month);
      end
    end
  end

`ifdef MONTH_YEAR_BCD_OUT_EN
  // Months are shown 1-based (01..12); years as stored (00..99).
  always_ff @(posedge clk) begin
    if (clear) begin
      month_bcd <= 8'h00;
      year_bcd  <= 8'h00;
    end else begin
      month_bcd <= bin2bcd({3'b000, month} + 7'd1);
      year_bcd  <= bin2bcd(7'(year));
    end
  end
`endif

endmodule
